seq_detector_1011: RTL and testbench
====================================

SEQ_DETECTOR_1011 -- requirements
Module: seq_rtl

Interface
REQ-001 SHALL have parameter: OVERLAP, default 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: serial_in  input  1  serial data bit, one bit sampled per rising clk edge.
REQ-005 SHALL have port: detected  output  1  high for one cycle when the last four sampled bits (oldest first) equal 1011.

Function
REQ-006 SHALL implement a Moore FSM with five states: S0 (no prefix), S1 ("1"), S2 ("10"), S3 ("101"), S4 ("1011" matched).
REQ-007 SHALL transition on each rising clk edge as follows, for serial_in = 0 / 1:
- S0: 0 -> S0; 1 -> S1.
- S1: 0 -> S2; 1 -> S1.
- S2: 0 -> S0; 1 -> S3.
- S3: 0 -> S2; 1 -> S4.
REQ-008 SHALL, from S4 with OVERLAP=1: 0 -> S2, 1 -> S1 (trailing "1" reused).
REQ-009 SHALL, from S4 with OVERLAP=0: 0 -> S0, 1 -> S1 (no bit reused).
REQ-010 SHALL drive detected = 1 only while state is S4, decoded from the state register only, with no combinational path from serial_in.
REQ-011 SHALL assert detected in the cycle immediately after the edge that samples the final 1 of the pattern; latency is 1 clock.
REQ-012 SHALL hold detected high for exactly one cycle per match; back-to-back matches (S4 -> S4) are impossible because the minimum match spacing is 3 bits.
REQ-013 SHALL sample serial_in only on rising clk edges; glitches between edges have no effect.
REQ-014 SHALL encode states in 3 bits; unused encodings SHALL return to S0 on the next edge, with detected = 0.

Reset
REQ-015 SHALL, while rst = 1, force state to S0 and detected to 0 immediately, independent of clk.
REQ-016 SHALL discard any partial prefix when reset is asserted mid-sequence; after release, matching restarts from S0.
REQ-017 SHALL begin sampling serial_in on the first rising clk edge after rst deasserts.

Structure
REQ-018 SHALL place the state enum typedef (S0..S4, 3-bit) and the constant PATTERN = 4'b1011 in shared package seq_pkg.
REQ-019 SHALL consist of one state register process, one next-state combinational process, and one output decode.
REQ-020 SHALL be a single module with no sub-modules.

Verification
REQ-021 SHALL cover this scenario: reset held 15 ns, then 32 bits 10011011001001100000011010010110 MSB-first (bit index 0 first), one per cycle -> detected pulses exactly twice, one cycle after sampling bit 7 and after bit 30; otherwise 0.
REQ-022 SHALL cover this scenario: OVERLAP=1, input 1011011 -> two pulses, after bits 3 and 6.
REQ-023 SHALL cover this scenario: OVERLAP=0, input 1011011 -> one pulse, after bit 3 only.
REQ-024 SHALL cover this scenario: input 101, assert rst asynchronously between edges, release, then input 1 -> no pulse; detected 0 during reset.
REQ-025 SHALL cover this scenario: input 10101011 -> one pulse, after bit 7, confirming S3 --0--> S2 recovery.
REQ-026 SHALL cover this scenario: all-zeros and all-ones streams of 16 bits each -> detected never asserts.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
package seq_pkg;

  // Three-bit state encoding. Codes 5..7 are unused and recover to S0.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // no prefix
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "10"
    S3 = 3'd3,  // "101"
    S4 = 3'd4   // "1011" matched
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detector_1011.sv
// Moore FSM that detects the serial pattern 1011 (oldest bit first).
// The OVERLAP parameter selects whether the trailing 1 of a match may start the next match.
module seq_detector_1011
  import seq_pkg::*;
#(
  parameter int OVERLAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic detected
);

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S0;
    case (state)
      S0: state_nxt = serial_in ? S1 : S0;
      S1: state_nxt = serial_in ? S1 : S2;
      S2: state_nxt = serial_in ? S3 : S0;
      S3: state_nxt = serial_in ? S4 : S2;
      // Overlapping mode keeps the trailing "1" of the match as a fresh prefix.
      S4: state_nxt = serial_in ? S1 : ((OVERLAP != 0) ? S2 : S0);
      default: state_nxt = S0;
    endcase
  end

  // The output is decoded from the state register alone, so there is no path from serial_in.
  assign detected = (state == S4);

endmodule

// File: tb/tb_seq_detector_1011.sv
// Scoreboard bench for seq_detector_1011. The bench drives overlapping and non-overlapping
// instances side by side, using hand-computed pulse masks for each directed vector.
module tb_seq_detector_1011;

  logic clk = 1'b1;
  logic rst;
  logic serial_in;
  logic det_ov, det_no;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic exp;
    int   tag;
  } exp_t;

  exp_t q_ov[$];
  exp_t q_no[$];

  always #5 clk = ~clk;

  seq_detector_1011 #(.OVERLAP(1)) u_ov (
    .clk(clk), .rst(rst), .serial_in(serial_in), .detected(det_ov)
  );
  seq_detector_1011 #(.OVERLAP(0)) u_no (
    .clk(clk), .rst(rst), .serial_in(serial_in), .detected(det_no)
  );

  task automatic chk(input string name, input int tag, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s tag=%0d got=%b want=%b t=%0t", name, tag, act, exp, $time);
    end
  endtask

  // Monitor: each negedge after a sampled bit presents the registered detect output.
  always @(negedge clk) begin
    exp_t e;
    if (q_ov.size() > 0) begin
      e = q_ov.pop_front();
      chk("det_ov", e.tag, det_ov, e.exp);
    end
    if (q_no.size() > 0) begin
      e = q_no.pop_front();
      chk("det_no", e.tag, det_no, e.exp);
    end
  end

  // Bit k of a vector is v[n-1-k], so the literals read first-bit-first.
  task automatic run_vec(input int id, input int n, input logic [31:0] bits,
                         input logic [31:0] m_ov, input logic [31:0] m_no);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      serial_in = bits[n-1-k];
      @(posedge clk);
      q_ov.push_back('{exp: m_ov[n-1-k], tag: id * 100 + k});
      q_no.push_back('{exp: m_no[n-1-k], tag: id * 100 + k});
    end
  endtask

  // Reset is asserted between edges, so the output must clear before any clock edge arrives.
  task automatic do_reset(input int id);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ov", id, det_ov, 1'b0);
    chk("rst_async_no", id, det_no, 1'b0);
    @(negedge clk);
    chk("rst_hold_ov", id, det_ov, 1'b0);
    chk("rst_hold_no", id, det_no, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    serial_in = 1'b0;
    #14;
    chk("reset_ov", 0, det_ov, 1'b0);
    chk("reset_no", 0, det_no, 1'b0);
    #1 rst = 1'b0;

    // Long stream: pulses after bits 7 and 30 in both modes.
    run_vec(1, 32, 32'b10011011001001100000011010010110,
                   32'b00000001000000000000000000000010,
                   32'b00000001000000000000000000000010);
    do_reset(1);

    // The overlap mode reuses the trailing 1.
    run_vec(2, 7, 32'b1011011, 32'b0001001, 32'b0001000);
    do_reset(2);

    run_vec(3, 10, 32'b1011011011, 32'b0001001001, 32'b0001000001);
    do_reset(3);

    // S3 --0--> S2 recovery.
    run_vec(4, 8, 32'b10101011, 32'b00000001, 32'b00000001);
    do_reset(4);

    // A partial prefix is discarded by reset.
    run_vec(5, 3, 32'b101, 32'b000, 32'b000);
    do_reset(5);
    run_vec(6, 1, 32'b1, 32'b0, 32'b0);
    do_reset(6);

    // Reset taken while detected is high must drop it immediately.
    run_vec(7, 4, 32'b1011, 32'b0001, 32'b0001);
    do_reset(7);

    run_vec(8, 16, 32'h0000, 32'h0000, 32'h0000);
    do_reset(8);
    run_vec(9, 16, 32'hFFFF, 32'h0000, 32'h0000);

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drain_ov", 99, q_ov.size() == 0, 1'b1);
    chk("queue_drain_no", 99, q_no.size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
